tdm_demux4x1: RTL
=================

# tdm_demux4x1

Receive-side counterpart of the 4:1 multiplexer. It samples a serial time-division stream, which a 4:1 mux produces by cycling its select 00→01→10→11, and rebuilds the 4-bit parallel word `i` at the far end of the link. Slot 0 of each frame carries a frame marker. The block locks onto that marker, tracks the slot index, and emits one parallel word per frame with a single-cycle valid strobe. It flags framing errors and resynchronises on its own.

## Interface
- `N`, default 4: channels per frame; power of two, ≥2.
- `SW`, default 2: slot-index width, equal to log2(N).
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `en`, input, 1: slot strobe; `din`/`sync` are sampled only when `en`=1.
- `din`, input, 1: serial data, i.e. the mux output `o` for the current slot.
- `sync`, input, 1: frame marker, high with slot 0 only.
- `o`, output, N: last complete reconstructed word; `o[k]` is the bit received in slot k.
- `valid`, output, 1: one-cycle pulse when `o` updates.
- `s`, output, SW: slot index expected on the next `en`.
- `locked`, output, 1: high in the RUN state.
- `err`, output, 1: one-cycle pulse on a framing error.

## Operation
- Reset values (asynchronous, while `rst`=1): `o`=0, `valid`=0, `err`=0, `s`=0, `locked`=0, staging register=0, state HUNT.
- HUNT state:
  - `en`=1 with `sync`=0: sample ignored, no `err`.
  - `en`=1 with `sync`=1: `din` goes to staging bit 0, `s`←1, go to RUN.
- RUN state, for each `en`=1 cycle:
  - `s`≠0, `sync`=0: `din` goes to staging bit `s`, and `s`←`s`+1.
  - `s`=N−1: `o`←{`din`, staging[N−2:0]}, `valid` pulses, `s` wraps to 0.
  - `s`=0, `sync`=1: normal frame start; `din` goes to staging bit 0, `s`←1.
  - `s`=0, `sync`=0 (marker missing): `err` pulses, sample discarded, staging cleared, `s`←0, go to HUNT.
  - `s`≠0, `sync`=1 (early marker): `err` pulses, partial frame discarded with no `valid`, and this sample is treated as slot 0.
    - Staging←{0…, `din`}, `s`←1, stay in RUN.
- `en`=0: all state holds; `valid`/`err` deassert the next cycle.
- `o` holds its value between frames. Staging is internal and never appears on `o` until the frame completes.
- No backpressure. A downstream consumer that misses `valid` loses that word.
- `locked`=1 exactly when the state is RUN.

## Timing
- All outputs are registered and update on the rising `clk`.
- Latency: `o`/`valid` appear one cycle after the `en` cycle that carries slot N−1.
- Back-to-back slots (`en`=1 every cycle) give one `valid` every N cycles. There is no dead cycle between frames.
- `valid` and `err` are never high in the same cycle.
- `rst` asserted mid-frame: outputs clear immediately without waiting for `clk`; the partial frame is lost. After deassertion the block waits in HUNT for the next `sync`.
- `s` is the slot the next sample will fill. It must match the transmitting mux select when locked.

## Test plan
- Reset:
  - Stimulus: assert `rst` asynchronously between clock edges.
  - Required: `o`=0000, `valid`=0, `err`=0, `s`=00, `locked`=0 before the next edge.
- Basic frame:
  - Stimulus: `en`=1 each cycle; `din`=0,1,0,1 for slots 0..3 with `sync` on slot 0. This is word 4'b1010, matching the mux bench pattern.
  - Required: `o`=4'b1010 and a single `valid` pulse one cycle after slot 3; `locked`=1 from slot 1 on.
- Streaming and gaps:
  - Stimulus: three consecutive frames 1010, 0101, 1111 with `en` held high. Then repeat with `en` low for 2 cycles between each slot.
  - Required: three `valid` pulses, N cycles apart in the first run. Identical `o` sequence in the gapped run, and `s` held during the gaps.
- Missing marker:
  - Stimulus: after frame 1010, send slot 0 with `sync`=0.
  - Required: `err` pulse, `locked`→0, `o` stays 1010. The following `sync` frame 0110 yields `o`=0110.
- Early marker:
  - Stimulus: `sync`=1 at `s`=10 mid-frame, followed by 3 more slots carrying 1,1,0.
  - Required: `err` pulse, no `valid` for the aborted frame, `locked` stays 1. The new frame completes with `o` = {0,1,1,din_at_marker}.
- Reset mid-frame:
  - Stimulus: assert `rst` at `s`=10.
  - Required: no `valid`, `o`=0. The block stays unlocked until the next `sync`.

Source files
------------

// File: rtl/tdm_demux4x1.sv
// Receive-side TDM demultiplexer: locks onto the slot-0 frame marker and rebuilds the
// N-bit parallel word from a serial slot stream, with framing-error detection.
module tdm_demux4x1 #(
    parameter int unsigned N  = 4,
    parameter int unsigned SW = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic          din_i,
    input  logic          sync_i,
    output logic [N-1:0]  o_o,
    output logic          valid_o,
    output logic [SW-1:0] s_o,
    output logic          locked_o,
    output logic          err_o
);

    typedef enum logic {StHunt, StRun} state_e;

    localparam logic [SW-1:0] LastSlot = SW'(N - 1);
    localparam logic [SW-1:0] FirstFill = SW'(1);

    state_e        state_q, state_d;
    logic [N-1:0]  stage_q, stage_d;
    logic [N-1:0]  o_q, o_d;
    logic [SW-1:0] s_q, s_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StHunt;
            stage_q <= '0;
            o_q     <= '0;
            s_q     <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            o_q     <= o_d;
            s_q     <= s_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        o_d     = o_q;
        s_d     = s_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (en_i) begin
            unique case (state_q)
                StHunt: begin
                    if (sync_i) begin
                        stage_d    = '0;
                        stage_d[0] = din_i;
                        s_d        = FirstFill;
                        state_d    = StRun;
                    end
                end
                StRun: begin
                    if (sync_i) begin
                        // A marker anywhere but slot 0 aborts the partial frame and restarts it.
                        err_d      = (s_q != '0);
                        stage_d    = '0;
                        stage_d[0] = din_i;
                        s_d        = FirstFill;
                    end else if (s_q == '0) begin
                        err_d   = 1'b1;
                        stage_d = '0;
                        s_d     = '0;
                        state_d = StHunt;
                    end else if (s_q == LastSlot) begin
                        o_d     = {din_i, stage_q[N-2:0]};
                        valid_d = 1'b1;
                        s_d     = '0;
                    end else begin
                        stage_d[s_q] = din_i;
                        s_d          = s_q + FirstFill;
                    end
                end
                default: state_d = StHunt;
            endcase
        end
    end

    assign o_o      = o_q;
    assign valid_o  = valid_q;
    assign err_o    = err_q;
    assign s_o      = s_q;
    assign locked_o = (state_q == StRun);

endmodule
